// File: rtl/fc_net_sched_pkg.sv
// Shared types, sizes and helpers for the two-layer FC network scheduler.
package fc_net_sched_pkg;

  localparam int M1  = 6;
  localparam int N1  = 6;
  localparam int M2  = 4;
  localparam int LAT = 2;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int XW = $clog2(max(N1, M1));
  localparam int WW = $clog2(max(M1 * N1, M2 * M1));
  localparam int HW = $clog2(M1);

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    L1_MAC   = 3'd1,
    L1_DRAIN = 3'd2,
    L1_STORE = 3'd3,
    L2_MAC   = 3'd4,
    L2_DRAIN = 3'd5,
    L2_OUT   = 3'd6
  } state_t;

endpackage

// File: rtl/fc_net_sched_if.sv
// Stream handshakes plus datapath/memory controls of the FC scheduler.
interface fc_net_sched_if;
  import fc_net_sched_pkg::*;

  // Valid/ready: a word or result transfers on a cycle where valid and ready
  // are both high; valid, once raised, holds with its data until that cycle.
  logic          input_valid;
  logic          input_ready;
  logic          output_valid;
  logic          output_ready;
  logic          layer;
  logic          wr_en_x;
  logic [XW-1:0] addr_x_wr;
  logic [XW-1:0] addr_x_rd;
  logic [WW-1:0] addr_w;
  logic          en_acc;
  logic          clear_acc;
  logic          wr_en_h;
  logic [HW-1:0] addr_h;

  modport master (
    input  input_valid, output_ready,
    output input_ready, output_valid, layer, wr_en_x, addr_x_wr, addr_x_rd,
           addr_w, en_acc, clear_acc, wr_en_h, addr_h
  );

  modport slave (
    output input_valid, output_ready,
    input  input_ready, output_valid, layer, wr_en_x, addr_x_wr, addr_x_rd,
           addr_w, en_acc, clear_acc, wr_en_h, addr_h
  );

endinterface

// File: rtl/fc_net_sched_pipe.sv
// Delay line of the MAC issue strobe; its tail is the accumulator enable.
module fc_net_sched_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  output logic en_o
);

  logic [LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = issue_i;
  end

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign en_o = sr_q[LAT-1];

endmodule

// File: rtl/fc_net_sched.sv
// FSM and counters sequencing input load, layer-1 MAC/ReLU store and
// layer-2 MAC/output over one shared MAC datapath.
module fc_net_sched
  import fc_net_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  fc_net_sched_if.master        bus,
  output state_t                state_o
);

  localparam int RW = max(1, $clog2(max(M1, M2)));
  localparam int DW = max(1, $clog2(LAT));

  state_t        state_q, state_d;
  logic [XW-1:0] k_q, k_d;
  logic [XW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          issue;
  logic          pipe_en;

  assign issue   = ((state_q == L1_MAC) || (state_q == L2_MAC)) && !reset;
  assign state_o = state_q;

  fc_net_sched_pipe #(.LAT(LAT)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .issue_i (issue),
    .en_o    (pipe_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    col_d            = col_q;
    row_d            = row_q;
    dcnt_d           = dcnt_q;
    bus.input_ready  = 1'b0;
    bus.output_valid = 1'b0;
    bus.layer        = 1'b0;
    bus.wr_en_x      = 1'b0;
    bus.addr_x_wr    = '0;
    bus.addr_x_rd    = '0;
    bus.addr_w       = '0;
    bus.en_acc       = pipe_en;
    bus.clear_acc    = 1'b0;
    bus.wr_en_h      = 1'b0;
    bus.addr_h       = '0;
    case (state_q)
      LOAD: begin
        bus.input_ready = 1'b1;
        bus.wr_en_x     = bus.input_valid;
        bus.addr_x_wr   = k_q;
        if (bus.input_valid) begin
          if (k_q == XW'(N1 - 1)) begin
            k_d     = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = L1_MAC;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      L1_MAC: begin
        bus.addr_x_rd = col_q;
        bus.addr_w    = WW'(row_q) * WW'(N1) + WW'(col_q);
        if (col_q == XW'(N1 - 1)) begin
          col_d   = '0;
          dcnt_d  = '0;
          state_d = L1_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      L1_DRAIN: begin
        if (dcnt_q == DW'(LAT - 1)) state_d = L1_STORE;
        else                        dcnt_d  = dcnt_q + 1'b1;
      end
      L1_STORE: begin
        // H latches the accumulator in the same cycle the clear is applied.
        bus.wr_en_h   = 1'b1;
        bus.addr_h    = HW'(row_q);
        bus.clear_acc = 1'b1;
        if (row_q == RW'(M1 - 1)) begin
          row_d   = '0;
          state_d = L2_MAC;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = L1_MAC;
        end
      end
      L2_MAC: begin
        bus.layer     = 1'b1;
        bus.addr_x_rd = col_q;
        bus.addr_w    = WW'(row_q) * WW'(M1) + WW'(col_q);
        if (col_q == XW'(M1 - 1)) begin
          col_d   = '0;
          dcnt_d  = '0;
          state_d = L2_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      L2_DRAIN: begin
        bus.layer = 1'b1;
        if (dcnt_q == DW'(LAT - 1)) state_d = L2_OUT;
        else                        dcnt_d  = dcnt_q + 1'b1;
      end
      L2_OUT: begin
        bus.layer        = 1'b1;
        bus.output_valid = 1'b1;
        if (bus.output_ready) begin
          bus.clear_acc = 1'b1;
          if (row_q == RW'(M2 - 1)) begin
            row_d   = '0;
            state_d = LOAD;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = L2_MAC;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    // Reset forces a quiet datapath with the accumulator held clear.
    if (reset) begin
      bus.input_ready  = 1'b0;
      bus.output_valid = 1'b0;
      bus.layer        = 1'b0;
      bus.wr_en_x      = 1'b0;
      bus.addr_x_wr    = '0;
      bus.addr_x_rd    = '0;
      bus.addr_w       = '0;
      bus.en_acc       = 1'b0;
      bus.clear_acc    = 1'b1;
      bus.wr_en_h      = 1'b0;
      bus.addr_h       = '0;
    end
  end

endmodule

// File: tb/tb_fc_net_sched.sv
// Directed bench for fc_net_sched: per-cycle expected control vectors go into
// a queue; a negedge monitor pops and compares against the DUT outputs.
module tb_fc_net_sched;
  import fc_net_sched_pkg::*;

  localparam int W = 1 + 1 + XW + 1 + XW + WW + 1 + 1 + 1 + HW + 1;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  fc_net_sched_if bus ();

  fc_net_sched dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_passed = 0;
  logic [W-1:0] obs;

  assign obs = {bus.input_ready, bus.wr_en_x, bus.addr_x_wr, bus.layer, bus.addr_x_rd,
                bus.addr_w, bus.en_acc, bus.clear_acc, bus.wr_en_h, bus.addr_h,
                bus.output_valid};

  function automatic logic [W-1:0] pack(input int ir, input int wx, input int axw,
                                        input int lay, input int axr, input int aw,
                                        input int en, input int clr, input int wh,
                                        input int ah, input int ov);
    return {ir[0], wx[0], axw[XW-1:0], lay[0], axr[XW-1:0], aw[WW-1:0],
            en[0], clr[0], wh[0], ah[HW-1:0], ov[0]};
  endfunction

  // Driver tasks
  task automatic step(input logic rst, input logic iv, input logic ordy,
                      input logic [W-1:0] exp, input string tag);
    @(posedge clk);
    #1;
    reset            = rst;
    bus.input_valid  = iv;
    bus.output_ready = ordy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, 1'b1, pack(0,0,0,0,0,0,0,1,0,0,0), $sformatf("reset c%0d", i));
  endtask

  task automatic load_vec(input bit gaps);
    for (int k = 0; k < N1; k++) begin
      step(1'b0, 1'b1, 1'b1, pack(1,1,k,0,0,0,0,0,0,0,0), $sformatf("load k%0d", k));
      if (gaps && k < N1 - 1)
        step(1'b0, 1'b0, 1'b1, pack(1,0,k+1,0,0,0,0,0,0,0,0), $sformatf("load gap k%0d", k));
    end
  endtask

  task automatic l1_mac(input int r, input int ncols);
    for (int p = 0; p < ncols; p++)
      step(1'b0, 1'b1, 1'b1, pack(0,0,0,0,p,r*N1+p,(p >= LAT),0,0,0,0),
           $sformatf("l1 mac r%0d p%0d", r, p));
  endtask

  task automatic l1_row(input int r);
    l1_mac(r, N1);
    for (int d = 0; d < LAT; d++)
      step(1'b0, 1'b1, 1'b1, pack(0,0,0,0,0,0,1,0,0,0,0), $sformatf("l1 drain r%0d d%0d", r, d));
    step(1'b0, 1'b1, 1'b1, pack(0,0,0,0,0,0,0,1,1,r,0), $sformatf("l1 store r%0d", r));
  endtask

  task automatic l2_row(input int j, input int stall);
    for (int q = 0; q < M1; q++)
      step(1'b0, 1'b1, 1'b1, pack(0,0,0,1,q,j*M1+q,(q >= LAT),0,0,0,0),
           $sformatf("l2 mac r%0d q%0d", j, q));
    for (int d = 0; d < LAT; d++)
      step(1'b0, 1'b1, 1'b1, pack(0,0,0,1,0,0,1,0,0,0,0), $sformatf("l2 drain r%0d d%0d", j, d));
    for (int s = 0; s < stall; s++)
      step(1'b0, 1'b1, 1'b0, pack(0,0,0,1,0,0,0,0,0,0,1), $sformatf("l2 stall r%0d s%0d", j, s));
    step(1'b0, 1'b1, 1'b1, pack(0,0,0,1,0,0,0,1,0,0,1), $sformatf("l2 out r%0d", j));
  endtask

  task automatic full_run(input int stall_row, input int stall_n);
    for (int r = 0; r < M1; r++) l1_row(r);
    for (int j = 0; j < M2; j++) l2_row(j, (j == stall_row) ? stall_n : 0);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_passed, n_checks);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (obs === e) n_passed++;
      else $display("FAIL %s: got %h expected %h", t, obs, e);
    end
  end

  // Stimulus
  initial begin
    reset            = 1'b1;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;

    do_reset(2);
    load_vec(1'b0);
    full_run(2, 10);

    load_vec(1'b1);
    for (int r = 0; r < 3; r++) l1_row(r);
    l1_mac(3, 3);
    do_reset(2);
    step(1'b0, 1'b0, 1'b1, pack(1,0,0,0,0,0,0,0,0,0,0), "post-reset load");

    load_vec(1'b0);
    full_run(-1, 0);
    step(1'b0, 1'b0, 1'b0, pack(1,0,0,0,0,0,0,0,0,0,0), "final load idle");

    @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    summary();
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: run did not complete, required completion by 200000");
    summary();
    $finish;
  end

endmodule

// File: doc/fc_net_sched.md
Name: fc_net_sched

Overview:
Scheduler for a two-layer fully-connected network that time-shares one MAC datapath. The datapath is a registered vector read, a registered weight ROM read, a saturating multiply register and a saturating accumulator.
The block loads an N1-word input vector, then runs layer 1 (M1 x N1, ReLU), writing the results into a hidden buffer. It then runs layer 2 (M2 x M1) from that buffer and streams M2 results out.
It drives only addresses, enables and handshakes. It sits between the stream interface and the existing datapath, memories and ROMs.

Parameters:
M1, 6, layer-1 output count (also the layer-2 input length)
N1, 6, layer-1 input vector length
M2, 4, layer-2 output count
LAT, 2, cycles from an address issue to its product at the accumulator input
XW, $clog2(max(N1,M1)), vector-address width (localparam)
WW, $clog2(max(M1*N1,M2*M1)), weight-address width (localparam)
HW, $clog2(M1), hidden-address width (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
input_valid  in  1  input word present
input_ready  out  1  input word accepted this cycle when input_valid is also high
output_valid  out  1  datapath output_data holds a layer-2 result
output_ready  in  1  downstream accepts the result
layer  out  1  0 = layer 1 (ROM W1, vector buffer X); 1 = layer 2 (ROM W2, hidden buffer H)
wr_en_x  out  1  write input word into X
addr_x_wr  out  XW  X write address
addr_x_rd  out  XW  read address into X (layer 0) or H (layer 1)
addr_w  out  WW  weight ROM address
en_acc  out  1  accumulator load enable
clear_acc  out  1  accumulator clear; has priority over en_acc
wr_en_h  out  1  write ReLU'd accumulator into H
addr_h  out  HW  H write address

Behaviour:
- Single clock domain; all state updates on posedge clk. Outputs are combinational from state and counters.
- While reset is high:
  - clear_acc = 1.
  - All other outputs = 0.
  - State becomes LOAD and all counters go to 0.
- A reset mid-operation abandons the current vector completely; the accumulator is cleared.
- States: LOAD, L1_MAC, L1_DRAIN, L1_STORE, L2_MAC, L2_DRAIN, L2_OUT.
- LOAD:
  - input_ready = 1.
  - wr_en_x = input_valid.
  - addr_x_wr = word count k.
  - k increments on each accepted word. After the N1-th accept, go to L1_MAC with row = 0, col = 0.
  - input_ready = 0 in every other state.
- L1_MAC: issues one MAC per cycle.
  - layer = 0.
  - addr_x_rd = col.
  - addr_w = row*N1 + col.
  - After col = N1-1, go to L1_DRAIN.
- Issue pipeline: an LAT-deep delay line of the issue strobe. en_acc is high exactly LAT cycles after each issue cycle.
- L1_DRAIN: LAT cycles with no issue.
- L1_STORE: one cycle.
  - wr_en_h = 1, addr_h = row.
  - clear_acc = 1 in the same cycle; H captures the pre-clear value.
  - If row = M1-1, go to L2_MAC with row = 0. Otherwise increment row and go to L1_MAC.
- L2_MAC:
  - layer = 1.
  - addr_x_rd = col, 0..M1-1.
  - addr_w = row*M1 + col.
  - Then L2_DRAIN for LAT cycles, then L2_OUT.
- L2_OUT:
  - output_valid = 1, held stable until output_ready = 1.
  - On the handshake cycle clear_acc = 1. Then go to the next row's L2_MAC, or to LOAD after row M2-1.
  - output_ready is ignored outside L2_OUT.
- Cycle budget:
  - N1+LAT+1 cycles per layer-1 row.
  - M1+LAT cycles per layer-2 row, plus a minimum of 1 cycle in L2_OUT.
- Addresses and row/col counters never exceed their limits. addr_w and addr_x_rd are 0 outside the MAC states.

Decomposition:
- Package fc_net_sched_pkg holds:
  - the state_t enum (3 bits);
  - a max() function;
  - the width localparams XW, WW and HW.
- Sub-module fc_net_sched_pipe (LAT-deep, synchronous-reset shift register of the issue strobe) generates en_acc. It is cleared on reset.
- The FSM and counters stay in the top level.

Test Plan:
- Reset high for 2 cycles, then input_valid = 1 continuously -> input_ready high 6 cycles, addr_x_wr 0..5, wr_en_x high on those 6 cycles, then input_ready = 0.
- Call the 6th accept cycle 0 -> addr_w issues 0..5 in cycles 1..6, en_acc high cycles 3..8, wr_en_h with addr_h = 0 and clear_acc in cycle 9. Row 5 issues addr_w 30..35 and stores in cycle 54.
- Continue the same run -> layer = 1 from cycle 55, addr_w 0..5 and addr_x_rd 0..5 in cycles 55..60, output_valid first high in cycle 63. With output_ready = 1, the next output_valid is in cycle 72; the 4th result is followed by LOAD with input_ready = 1.
- Hold output_ready = 0 for 10 cycles in L2_OUT -> output_valid stays 1, clear_acc and addr_w stay 0, no issues. Release -> one handshake, then normal progress.
- Toggle input_valid 1,0,1,0 in LOAD -> only valid cycles are written; addr_x_wr advances only on accepts.
- Assert reset during layer-1 row 3 -> clear_acc = 1 while reset is high, every other output 0. The cycle after release: input_ready = 1 and addr_x_wr = 0.
